// File: rtl/ddr5_req_queue.sv
// ddr5_req_queue: time-gated circular request queue with DDR5 address decode registered at enqueue
module ddr5_req_queue #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 34,
  parameter int CYC_W = 64,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter bit TIME_GATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [CYC_W-1:0]         now_cyc,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CYC_W-1:0]         in_cyc,
  input  logic [3:0]               in_core,
  input  logic [1:0]               in_opn,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W-1:0]         out_cyc,
  output logic [3:0]               out_core,
  output logic [1:0]               out_opn,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [ADDR_W-19:0]       out_row,
  output logic [1:0]               out_bank,
  output logic [2:0]               out_bg,
  output logic                     out_channel,
  output logic [9:0]               out_column,
  output logic [1:0]               out_byte,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = ADDR_W - 18;
  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [3:0]        core;
    logic [1:0]        opn;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     row;
    logic [1:0]        bank;
    logic [2:0]        bg;
    logic              ch;
    logic [9:0]        column;
    logic [1:0]        byt;
  } ent_t;
  ent_t mem_q [DEPTH];
  ent_t ent_d, head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic enq, deq;
  always_comb begin
    ent_d = '{cyc: in_cyc, core: in_core, opn: in_opn, addr: in_addr, row: in_addr[ADDR_W-1:18],
              bank: in_addr[11:10], bg: in_addr[9:7], ch: in_addr[6],
              column: {in_addr[17:12], in_addr[5:2]}, byt: in_addr[1:0]};
    head = mem_q[rd_q];
    enq = in_valid && in_ready;
    deq = out_valid && out_ready;
    wr_d = flush ? '0 : wr_q + PW'(enq);
    rd_d = flush ? '0 : rd_q + PW'(deq);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_q] <= ent_d;
  end
  assign count = cnt_q;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign almost_full = cnt_q >= (PW+1)'(AFULL_LVL);
  assign in_ready = !full && !rst;
  assign out_valid = !empty && (!TIME_GATE || now_cyc >= head.cyc);
  assign out_cyc = head.cyc;
  assign out_core = head.core;
  assign out_opn = head.opn;
  assign out_addr = head.addr;
  assign out_row = head.row;
  assign out_bank = head.bank;
  assign out_bg = head.bg;
  assign out_channel = head.ch;
  assign out_column = head.column;
  assign out_byte = head.byt;
endmodule

// File: tb/tb_ddr5_req_queue.sv
// tb_ddr5_req_queue: queue-model scoreboard plus directed literal checks for ddr5_req_queue
module tb_ddr5_req_queue;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0, g_in_valid = 0, g_out_ready = 0;
  logic [63:0] now_cyc = '0, in_cyc = '0;
  logic [3:0] in_core = '0;
  logic [1:0] in_opn = '0;
  logic [33:0] in_addr = '0;
  logic in_ready, out_valid, out_channel, full, empty, almost_full;
  logic [63:0] out_cyc;
  logic [3:0] out_core;
  logic [1:0] out_opn, out_bank, out_byte;
  logic [33:0] out_addr;
  logic [15:0] out_row;
  logic [2:0] out_bg;
  logic [9:0] out_column;
  logic [4:0] count;
  logic g_in_ready, g_out_valid, g_out_channel, g_full, g_empty, g_almost_full;
  logic [63:0] g_out_cyc;
  logic [3:0] g_out_core;
  logic [1:0] g_out_opn, g_out_bank, g_out_byte;
  logic [33:0] g_out_addr;
  logic [15:0] g_out_row;
  logic [2:0] g_out_bg;
  logic [9:0] g_out_column;
  logic [4:0] g_count;
  ddr5_req_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .now_cyc(now_cyc), .in_valid(in_valid), .in_ready(in_ready),
    .in_cyc(in_cyc), .in_core(in_core), .in_opn(in_opn), .in_addr(in_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_cyc(out_cyc), .out_core(out_core), .out_opn(out_opn), .out_addr(out_addr),
    .out_row(out_row), .out_bank(out_bank), .out_bg(out_bg), .out_channel(out_channel),
    .out_column(out_column), .out_byte(out_byte), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full));
  ddr5_req_queue #(.TIME_GATE(0)) dut_ng (
    .clk(clk), .rst(rst), .flush(1'b0), .now_cyc(now_cyc), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_cyc(in_cyc), .in_core(in_core), .in_opn(in_opn), .in_addr(in_addr), .out_valid(g_out_valid),
    .out_ready(g_out_ready), .out_cyc(g_out_cyc), .out_core(g_out_core), .out_opn(g_out_opn),
    .out_addr(g_out_addr), .out_row(g_out_row), .out_bank(g_out_bank), .out_bg(g_out_bg),
    .out_channel(g_out_channel), .out_column(g_out_column), .out_byte(g_out_byte), .count(g_count),
    .full(g_full), .empty(g_empty), .almost_full(g_almost_full));
  always #5 clk = ~clk;
  typedef struct {
    logic [63:0] cyc;
    logic [3:0]  core;
    logic [1:0]  opn;
    logic [33:0] addr;
  } req_t;
  req_t mq[$];
  int n_cmp = 0, n_bad = 0;
  bit armed = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic bit exp_valid();
    return mq.size() > 0 && now_cyc >= mq[0].cyc;
  endfunction
  always @(posedge clk) begin : model
    bit e, d;
    e = in_valid && !rst && mq.size() < 16;
    d = out_ready && exp_valid();
    if (rst || flush) mq.delete();
    else begin
      if (d) void'(mq.pop_front());
      if (e) mq.push_back('{in_cyc, in_core, in_opn, in_addr});
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 16);
      chk("almost_full", almost_full, mq.size() >= 14);
      chk("in_ready", in_ready, !rst && mq.size() < 16);
      chk("out_valid", out_valid, exp_valid());
      if (mq.size() > 0) begin
        chk("out_cyc", out_cyc, mq[0].cyc);
        chk("out_core", out_core, mq[0].core);
        chk("out_opn", out_opn, mq[0].opn);
        chk("out_addr", out_addr, mq[0].addr);
        chk("out_row", out_row, mq[0].addr >> 18);
        chk("out_bank", out_bank, (mq[0].addr >> 10) % 4);
        chk("out_bg", out_bg, (mq[0].addr >> 7) % 8);
        chk("out_channel", out_channel, (mq[0].addr >> 6) % 2);
        chk("out_column", out_column, ((mq[0].addr >> 12) % 64) * 16 + (mq[0].addr >> 2) % 16);
        chk("out_byte", out_byte, mq[0].addr % 4);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] c, input logic [33:0] a);
    in_valid = 1;
    in_cyc = c;
    in_addr = a;
    in_core = a[3:0];
    in_opn = a[5:4];
    step();
    in_valid = 0;
  endtask
  initial begin
    step();
    armed = 1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    now_cyc = 10;
    push(5, 34'h2AF36AEE6);
    chk("dec_valid", out_valid, 1);
    chk("dec_row", out_row, 'hABCD);
    chk("dec_column", out_column, 'h2A9);
    chk("dec_bank", out_bank, 3);
    chk("dec_bg", out_bg, 5);
    chk("dec_channel", out_channel, 1);
    chk("dec_byte", out_byte, 2);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("dec_drained", empty, 1);
    now_cyc = 90;
    g_in_valid = 1;
    push(100, 34'h777);
    g_in_valid = 0;
    chk("tg_hold", out_valid, 0);
    chk("tg_off_valid", g_out_valid, 1);
    chk("tg_off_addr", g_out_addr, 'h777);
    for (int n = 91; n <= 100; n++) begin
      now_cyc = 64'(n);
      step();
      chk("tg_gate", out_valid, n >= 100);
    end
    out_ready = 1;
    g_out_ready = 1;
    step();
    out_ready = 0;
    g_out_ready = 0;
    chk("tg_drain", empty, 1);
    chk("tg_off_drain", g_empty, 1);
    now_cyc = 1000;
    for (int i = 0; i < 16; i++) begin
      push(64'(i), 34'(i * 'h10441 + 'h100));
      if (i == 12) chk("afull_13", almost_full, 0);
      if (i == 13) chk("afull_14", almost_full, 1);
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = i < 8;
      in_cyc = 3;
      in_addr = 34'h300000000 + 34'(i);
      step();
    end
    in_valid = 0;
    out_ready = 0;
    chk("wrap_count", count, 7);
    flush = 1;
    in_valid = 1;
    out_ready = 1;
    in_addr = 34'h1234;
    step();
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_valid", out_valid, 0);
    step();
    chk("flush_not_stored", empty, 1);
    for (int i = 0; i < 5; i++) push(64'(i), 34'h5000 + 34'(i));
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_addr = 34'h6000 + 34'(i);
      in_cyc = 64'(i);
      step();
    end
    chk("simul_count", count, 5);
    in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 0;
    chk("simul_drain", empty, 1);
    for (int i = 0; i < 9; i++) push(2, 34'h8000 + 34'(i));
    chk("midrst_count9", count, 9);
    rst = 1;
    step();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_count", count, 0);
    rst = 0;
    step();
    chk("midrst_after_ready", in_ready, 1);
    push(7, 34'h123456789);
    chk("midrst_valid", out_valid, 1);
    chk("midrst_addr", out_addr, 34'h123456789);
    chk("midrst_row", out_row, 'h48D1);
    chk("midrst_bank", out_bank, 1);
    chk("midrst_byte", out_byte, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
